// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage: hold codes,
// NOP encoding, fetch exception causes and FSM state encodings.
package if_stage_pkg;

  localparam int HOLD_W  = 3;
  localparam int CAUSE_W = 4;

  typedef logic [HOLD_W-1:0]  bus_hold_code_t;
  typedef logic [CAUSE_W-1:0] bus_except_cause_t;

  localparam bus_hold_code_t HOLD_CODE_NONE = 3'd0;
  localparam bus_hold_code_t HOLD_CODE_IF   = 3'd2;
  localparam bus_hold_code_t HOLD_CODE_ID   = 3'd3;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam bus_except_cause_t EXCEPT_INSTR_MISALIGN = 4'd0;
  localparam bus_except_cause_t EXCEPT_INSTR_ACCESS   = 4'd1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: valid/ready request channel plus an
// always-accepted response channel.
interface if_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               req_o;
  logic [ADDR_W-1:0]  req_addr_o;
  logic               req_ready_i;
  logic               rsp_valid_i;
  logic [INSTR_W-1:0] rsp_data_i;
  logic               rsp_err_i;

  modport master (
    output req_o, req_addr_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i
  );

  modport slave (
    input  req_o, req_addr_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i
  );
endinterface

// File: rtl/if_queue.sv
// Two-entry FIFO with push/pop/flush; used for the prefetch queue and for
// the PCs of in-flight requests.
module if_queue #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push  = push && !flush && ((count_q != 2'd2) || pop);
    do_pop   = pop && !flush && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = !rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues fetches over the bus,
// buffers responses in a 2-entry prefetch queue and drives the IF/ID register.
module if_stage import if_stage_pkg::*; #(
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  bus_hold_code_t     hold_code,
  input  logic               jmp_en_i,
  input  logic [ADDR_W-1:0]  jmp_addr_i,
  if_stage_if.master         bus,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  addr_instr_o,
  output logic               fetch_except_o,
  output bus_except_cause_t  except_cause_o
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               exc;
    bus_except_cause_t  cause;
  } entry_t;

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(INSTR_NOP);
  localparam entry_t NOP_ENTRY = '{instr: NOP, pc: '0, exc: 1'b0, cause: '0};

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        outstanding_q, outstanding_d;
  logic [1:0]        drop_cnt_q, drop_cnt_d;
  logic              misal_pend_q, misal_pend_d;
  entry_t            ifid_q, ifid_d;

  logic   held, req, accept, rsp_fire, rsp_live, err_fire, kill, inject;
  logic   in_valid, bypass;
  entry_t in_entry;
  logic   q_push, q_pop, q_flush;
  logic [1:0] q_count;
  entry_t q_head;
  logic   a_push, a_pop, a_flush;
  logic [1:0] a_count;
  logic [ADDR_W-1:0] a_head;

  if_queue #(.W($bits(entry_t))) u_queue (
    .clk, .rst, .push(q_push), .pop(q_pop), .flush(q_flush),
    .push_data(in_entry), .count(q_count), .head(q_head)
  );

  // PCs of live (non-dropped) requests, in issue order.
  if_queue #(.W(ADDR_W)) u_addr_fifo (
    .clk, .rst, .push(a_push), .pop(a_pop), .flush(a_flush),
    .push_data(pc_q), .count(a_count), .head(a_head)
  );

  always_comb begin
    held     = hold_code >= HOLD_CODE_IF;
    req      = (state_q == ST_RUN) && (({1'b0, outstanding_q} + {1'b0, q_count}) < 3'd2);
    accept   = req && bus.req_ready_i;
    rsp_fire = bus.rsp_valid_i && (outstanding_q != 2'd0);
    rsp_live = rsp_fire && (drop_cnt_q == 2'd0) && (a_count != 2'd0) && !jmp_en_i;
    err_fire = rsp_live && bus.rsp_err_i;
    kill     = jmp_en_i || err_fire;
    inject   = misal_pend_q && (drop_cnt_q == 2'd0) && !jmp_en_i;
    in_valid = rsp_live || inject;

    in_entry.instr = err_fire ? NOP : bus.rsp_data_i;
    in_entry.pc    = a_head;
    in_entry.exc   = err_fire;
    in_entry.cause = err_fire ? EXCEPT_INSTR_ACCESS : '0;
    if (inject) begin
      in_entry.instr = NOP;
      in_entry.pc    = pc_q;
      in_entry.exc   = 1'b1;
      in_entry.cause = EXCEPT_INSTR_MISALIGN;
    end

    bypass  = in_valid && (q_count == 2'd0) && !held;
    q_flush = jmp_en_i;
    q_push  = in_valid && !bypass;
    q_pop   = !jmp_en_i && !held && (q_count != 2'd0);
    a_push  = accept && !kill;
    a_pop   = rsp_live;
    a_flush = kill;

    outstanding_d = outstanding_q + 2'(accept) - 2'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    if (kill) drop_cnt_d = outstanding_d;
    else if (rsp_fire && (drop_cnt_q != 2'd0)) drop_cnt_d = drop_cnt_q - 2'd1;

    pc_d = pc_q;
    if (jmp_en_i) pc_d = jmp_addr_i;
    else if (accept) pc_d = pc_q + ADDR_W'(4);

    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (err_fire) state_d = ST_FAULT;
      default:  state_d = state_q;
    endcase
    misal_pend_d = misal_pend_q && !inject;
    if (jmp_en_i) begin
      misal_pend_d = jmp_addr_i[1:0] != 2'b00;
      state_d      = misal_pend_d ? ST_FAULT : ST_RUN;
    end

    ifid_d = NOP_ENTRY;
    if (jmp_en_i) ifid_d = NOP_ENTRY;
    else if (held) ifid_d = ifid_q;
    else if (q_count != 2'd0) ifid_d = q_head;
    else if (bypass) ifid_d = in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
      misal_pend_q  <= 1'b0;
      ifid_q        <= NOP_ENTRY;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      misal_pend_q  <= misal_pend_d;
      ifid_q        <= ifid_d;
    end
  end

  assign bus.req_o      = req;
  assign bus.req_addr_o = pc_q;
  assign instr_o        = ifid_q.instr;
  assign addr_instr_o   = ifid_q.pc;
  assign fetch_except_o = ifid_q.exc;
  assign except_cause_o = ifid_q.cause;

endmodule
